// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared constants and init-FSM state encoding for the multi-port register file
package regfile_mp_pkg;
  localparam int REG_ZERO = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH = 32;
  typedef enum logic {RF_INIT = 1'b0, RF_READY = 1'b1} rf_state_e;
endpackage

// File: rtl/regfile_mp_rf_read_port.sv
// rf_read_port: one registered read port (addr -> zero/bypass/array select -> data_out), cleared while not ready
module rf_read_port
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [ADDR_W-1:0]             waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  output logic [DATA_W-1:0]             data_out
);
  logic [DATA_W-1:0] sel;
  always_comb sel = (ZERO_REG != 0 && addr == ADDR_W'(REG_ZERO)) ? '0 :
                    (BYPASS != 0 && we && addr == waddr) ? wdata : mem[addr];
  always_ff @(posedge clk) data_out <= (rst || !en) ? '0 : sel;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NUM_RD-read/1-write register file with post-reset clear sequencer; ports clk, rst, RegWrite, write_addr/data, read_addr -> data_out, ready
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       RegWrite,
  input  logic [ADDR_W-1:0]          write_addr,
  input  logic [DATA_W-1:0]          write_data,
  input  logic [NUM_RD*ADDR_W-1:0]   read_addr,
  output logic [NUM_RD*DATA_W-1:0]   data_out,
  output logic                       ready
);
  rf_state_e state;
  logic [ADDR_W-1:0] init_ptr;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic wr_ok;
  always_comb wr_ok = RegWrite && !(ZERO_REG != 0 && write_addr == ADDR_W'(REG_ZERO));
  always_ff @(posedge clk)
    if (rst) begin
      state <= RF_INIT;
      init_ptr <= '0;
      ready <= 1'b0;
    end else if (state == RF_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == ADDR_W'(DEPTH - 1)) begin
        state <= RF_READY;
        ready <= 1'b1;
      end
    end
  always_ff @(posedge clk)
    if (!rst) begin
      if (state == RF_INIT) mem[init_ptr] <= '0;
      else if (wr_ok) mem[write_addr] <= write_data;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_port (
      .clk(clk),
      .rst(rst),
      .en(state == RF_READY),
      .we(RegWrite),
      .addr(read_addr[k*ADDR_W +: ADDR_W]),
      .waddr(write_addr),
      .wdata(write_data),
      .mem(mem),
      .data_out(data_out[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed check of two regfile_mp configs against a behavioural model
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst, we;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [4:0] ra [3];
  logic [9:0] raddr_a;
  logic [14:0] raddr_b;
  logic [63:0] dout_a;
  logic [95:0] dout_b;
  logic ready_a, ready_b;
  int passed = 0, total = 0;
  bit started = 0;
  always #5 clk = ~clk;
  assign raddr_a = {ra[1], ra[0]};
  assign raddr_b = {ra[2], ra[1], ra[0]};
  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .RegWrite(we), .write_addr(wa), .write_data(wd),
    .read_addr(raddr_a), .data_out(dout_a), .ready(ready_a));
  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .RegWrite(we), .write_addr(wa), .write_data(wd),
    .read_addr(raddr_b), .data_out(dout_b), .ready(ready_b));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  // Model: cycles since reset count the clearing pass; afterwards reads see the
  // pre-write array (plus forwarding / zero rules for config A) and writes land.
  int cnt = 0;
  logic [31:0] ma [32], mb [32];
  logic [31:0] ea [2], eb [3];
  logic exp_ready = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      exp_ready = 1'b0;
      ea = '{default: 0};
      eb = '{default: 0};
    end else if (cnt < 32) begin
      ma[cnt] = 0;
      mb[cnt] = 0;
      cnt++;
      exp_ready = (cnt == 32);
      ea = '{default: 0};
      eb = '{default: 0};
    end else begin
      for (int k = 0; k < 2; k++)
        ea[k] = (ra[k] == 0) ? 32'h0 : (we && ra[k] == wa) ? wd : ma[ra[k]];
      for (int k = 0; k < 3; k++) eb[k] = mb[ra[k]];
      if (we) begin
        if (wa != 0) ma[wa] = wd;
        mb[wa] = wd;
      end
    end
  end
  always @(negedge clk)
    if (started) begin
      chk("ready_a", {31'b0, ready_a}, {31'b0, exp_ready});
      chk("ready_b", {31'b0, ready_b}, {31'b0, exp_ready});
      for (int k = 0; k < 2; k++) chk("port_a", dout_a[k*32 +: 32], ea[k]);
      for (int k = 0; k < 3; k++) chk("port_b", dout_b[k*32 +: 32], eb[k]);
    end
  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ready(input string nm, input bit poke);
    int n = 0;
    while (!ready_a && n < 40) begin
      we = poke && n == 5;
      wa = 5'd7;
      wd = 32'hDEADBEEF;
      @(negedge clk);
      n++;
    end
    we = 1'b0;
    chk(nm, n, 32);
  endtask
  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0;
    ra = '{default: 0};
    @(negedge clk);
    started = 1;
    pulse_rst();
    wait_ready("ready_latency", 1'b1);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(31 - a); ra[2] = 5'(a);
      @(negedge clk);
      chk("init_clear", dout_a[31:0], 32'h0);
    end
    ra[0] = 5'd7;
    @(negedge clk);
    chk("init_write_dropped_a", dout_a[31:0], 32'h0);
    chk("init_write_dropped_b", dout_b[31:0], 32'h0);
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra[0] = 5'd0;
    @(negedge clk);
    we = 1'b0;
    @(negedge clk);
    chk("zero_reg_a", dout_a[31:0], 32'h0);
    chk("zero_reg_b", dout_b[31:0], 32'h12345678);
    we = 1'b1; wa = 5'd4; wd = 32'h11;
    @(negedge clk);
    wa = 5'd3; wd = 32'hA5A5A5A5; ra[0] = 5'd3; ra[1] = 5'd4;
    @(negedge clk);
    we = 1'b0;
    chk("bypass_a_p0", dout_a[31:0], 32'hA5A5A5A5);
    chk("bypass_a_p1", dout_a[63:32], 32'h11);
    chk("nobypass_b_p0", dout_b[31:0], 32'h0);
    chk("nobypass_b_p1", dout_b[63:32], 32'h11);
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = a * 32'h01010101;
      @(negedge clk);
    end
    we = 1'b0;
    for (int a = 1; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(a); ra[2] = 5'(32 - a);
      @(negedge clk);
      chk("b2b_a_p0", dout_a[31:0], a * 32'h01010101);
      chk("b2b_a_p1", dout_a[63:32], a * 32'h01010101);
      chk("b2b_b_p2", dout_b[95:64], (32 - a) * 32'h01010101);
    end
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      we = $urandom_range(0, 1);
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wd = $urandom;
      for (int k = 0; k < 3; k++)
        ra[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; we = 1'b0;
    @(negedge clk);
    pulse_rst();
    repeat (10) @(negedge clk);
    pulse_rst();
    wait_ready("ready_mid_init", 1'b0);
    for (int a = 1; a < 32; a++) begin
      we = 1'b1; wa = 5'(a); wd = $urandom | 32'h1;
      @(negedge clk);
    end
    we = 1'b0;
    pulse_rst();
    wait_ready("ready_from_ready", 1'b0);
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a); ra[1] = 5'(a); ra[2] = 5'(a);
      @(negedge clk);
      chk("reclear_a", dout_a[63:32], 32'h0);
      chk("reclear_b", dout_b[95:64], 32'h0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
